// File: rtl/capture_readout_tx_if.sv
// Purpose : groups the capture-FIFO, byte-transmitter and status signals of capture_readout_tx.
// Latency : n/a (wires only).
// Backpressure: txBusy from the byte transmitter; dataReadyToRead/dataValid from the capture FIFO.
// Ports   : master = readout engine (drives dataRead, txData, txStart, busy, done, wordCount);
//           slave  = environment (drives readoutStart, dataReadyToRead, dataValid, dataIn, txBusy).
interface capture_readout_tx_if;
    logic        readoutStart;
    logic        dataReadyToRead;
    logic        dataValid;
    logic [15:0] dataIn;
    logic        dataRead;
    logic [7:0]  txData;
    logic        txStart;
    logic        txBusy;
    logic        busy;
    logic        done;
    logic [7:0]  wordCount;

    modport master (
        input  readoutStart, dataReadyToRead, dataValid, dataIn, txBusy,
        output dataRead, txData, txStart, busy, done, wordCount
    );

    modport slave (
        output readoutStart, dataReadyToRead, dataValid, dataIn, txBusy,
        input  dataRead, txData, txStart, busy, done, wordCount
    );
endinterface

// File: rtl/capture_readout_tx.sv
// Purpose : reads 16-bit words from a capture FIFO and streams them as HEADER, hi/lo bytes, XOR trailer.
// Latency : first byte offered 2 cycles after readoutStart; each byte offer follows a 1-cycle txStart gap.
// Backpressure: txStart/txData held while txBusy=1; FIFO starvation ends the packet after EMPTY_TIMEOUT idle cycles.
// Ports   : clk, rst_n (synchronous, active-low), bus (capture_readout_tx_if.master).
module capture_readout_tx #(
    parameter int unsigned NUM_WORDS     = 128,
    parameter logic [7:0]  HEADER        = 8'hA5,
    parameter int unsigned EMPTY_TIMEOUT = 1000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    capture_readout_tx_if.master        bus
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        SEND_HDR   = 3'd1,
        FETCH      = 3'd2,
        WAIT_VALID = 3'd3,
        SEND_HI    = 3'd4,
        SEND_LO    = 3'd5,
        SEND_TRL   = 3'd6
    } state_t;

    localparam logic [15:0] TIMEOUT_LAST = 16'(EMPTY_TIMEOUT - 1);
    localparam logic [7:0]  LAST_IDX     = 8'(NUM_WORDS - 1);

    state_t      state_q, state_d;
    logic        tx_start_q, tx_start_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        done_q, done_d;
    logic [7:0]  word_cnt_q, word_cnt_d;
    logic [7:0]  chk_q, chk_d;
    logic [15:0] idle_cnt_q, idle_cnt_d;
    logic [15:0] word_q, word_d;
    logic        data_read;
    logic [7:0]  byte_sel;
    logic        tx_xfer;
    logic        idle_cyc;
    logic        timeout;

    assign tx_xfer  = tx_start_q && !bus.txBusy;
    // Starvation: waiting for the FIFO to fill, or for read data to come back.
    assign idle_cyc = ((state_q == FETCH) && !bus.dataReadyToRead) ||
                      ((state_q == WAIT_VALID) && !bus.dataValid);
    // This cycle is the EMPTY_TIMEOUT-th consecutive idle one.
    assign timeout  = idle_cyc && (idle_cnt_q == TIMEOUT_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       if (bus.readoutStart) state_d = SEND_HDR;
            SEND_HDR:   if (tx_xfer) state_d = FETCH;
            FETCH: begin
                if (bus.dataReadyToRead) state_d = WAIT_VALID;
                else if (timeout)        state_d = SEND_TRL;
            end
            WAIT_VALID: begin
                if (bus.dataValid) state_d = SEND_HI;
                else if (timeout)  state_d = SEND_TRL;
            end
            SEND_HI:    if (tx_xfer) state_d = SEND_LO;
            SEND_LO: begin
                if (tx_xfer) state_d = (word_cnt_q == LAST_IDX) ? SEND_TRL : FETCH;
            end
            SEND_TRL:   if (tx_xfer) state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    // Byte offered in each send state
    always_comb begin
        byte_sel = 8'h00;
        case (state_q)
            SEND_HDR: byte_sel = HEADER;
            SEND_HI:  byte_sel = word_q[15:8];
            SEND_LO:  byte_sel = word_q[7:0];
            SEND_TRL: byte_sel = chk_q;
            default:  byte_sel = 8'h00;
        endcase
    end

    // Output / datapath next-state logic
    always_comb begin
        data_read   = 1'b0;
        tx_start_d  = tx_start_q;
        tx_data_d   = tx_data_q;
        done_d      = 1'b0;
        word_cnt_d  = word_cnt_q;
        chk_d       = chk_q;
        word_d      = word_q;
        idle_cnt_d  = (idle_cyc && !timeout) ? idle_cnt_q + 16'd1 : 16'd0;
        case (state_q)
            IDLE: begin
                if (bus.readoutStart) begin
                    word_cnt_d = 8'd0;
                    chk_d      = 8'h00;
                end
            end
            FETCH:      data_read = bus.dataReadyToRead;
            WAIT_VALID: if (bus.dataValid) word_d = bus.dataIn;
            SEND_HDR, SEND_HI, SEND_LO, SEND_TRL: begin
                // txStart is low on entry (the gap after the previous transfer);
                // use that cycle to load the byte, then hold it until accepted.
                if (!tx_start_q) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = byte_sel;
                end else if (!bus.txBusy) begin
                    tx_start_d = 1'b0;
                    if ((state_q == SEND_HI) || (state_q == SEND_LO)) chk_d = chk_q ^ tx_data_q;
                    if (state_q == SEND_LO)  word_cnt_d = word_cnt_q + 8'd1;
                    if (state_q == SEND_TRL) done_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
            done_q     <= 1'b0;
            word_cnt_q <= 8'd0;
            chk_q      <= 8'h00;
            idle_cnt_q <= 16'd0;
            word_q     <= 16'h0000;
        end else begin
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            done_q     <= done_d;
            word_cnt_q <= word_cnt_d;
            chk_q      <= chk_d;
            idle_cnt_q <= idle_cnt_d;
            word_q     <= word_d;
        end
    end

    assign bus.dataRead  = data_read;
    assign bus.txStart   = tx_start_q;
    assign bus.txData    = tx_data_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
    assign bus.wordCount = word_cnt_q;

endmodule

// File: tb/tb_capture_readout_tx.sv
// Purpose : self-checking bench for capture_readout_tx with a FIFO model, a byte sink and a packet model.
// Latency : n/a.
// Backpressure: sink asserts txBusy never / 10 cycles after each transfer / randomly, per test.
module tb_capture_readout_tx;
    localparam int         NW  = 2;
    localparam int         TO  = 8;
    localparam logic [7:0] HDR = 8'hA5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    capture_readout_tx_if bus();

    capture_readout_tx #(.NUM_WORDS(NW), .HEADER(HDR), .EMPTY_TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    int checks = 0;
    int errors = 0;

    logic [15:0] fifo_q[$];
    logic [15:0] pkt_words[$];
    logic [7:0]  rx[$];
    logic [7:0]  exp_q[$];
    int lat_min = 1;
    int lat_max = 1;
    int busy_mode = 0;
    int rd_count = 0;
    int proto_viol = 0;
    int done_cnt = 0;

    // Capture FIFO: read strobe seen before a rising edge pops a word at that edge,
    // dataValid follows after a configurable number of cycles.
    initial begin : fifo_proc
        int cd;
        bit rd_flag;
        logic [15:0] pend;
        cd = 0;
        rd_flag = 0;
        pend = 16'h0;
        forever begin
            @(negedge clk);
            bus.dataValid = 1'b0;
            bus.dataIn    = 16'($urandom);
            if (!rst_n) begin
                cd = 0;
                rd_flag = 0;
                fifo_q.delete();
            end else begin
                if (cd > 0) begin
                    cd--;
                    if (cd == 0) begin
                        bus.dataValid = 1'b1;
                        bus.dataIn    = pend;
                    end
                end
                if (rd_flag) begin
                    rd_flag = 0;
                    pend = (fifo_q.size() != 0) ? fifo_q.pop_front() : 16'hDEAD;
                    cd = $urandom_range(lat_max, lat_min) - 1;
                    if (cd == 0) begin
                        bus.dataValid = 1'b1;
                        bus.dataIn    = pend;
                    end
                end
            end
            bus.dataReadyToRead = (fifo_q.size() != 0);
            #1;
            if (rst_n && bus.dataRead) begin
                if (rd_flag || cd > 0) proto_viol++;
                rd_flag = 1;
                rd_count++;
            end
        end
    end

    // Byte transmitter sink and handshake monitor.
    initial begin : sink_proc
        bit p_start, p_xfer, b;
        logic [7:0] p_data;
        int bcnt;
        p_start = 0; p_xfer = 0; bcnt = 0; p_data = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                p_start = 0;
                p_xfer = 0;
                bcnt = 0;
                bus.txBusy = 1'b0;
            end else begin
                if (p_xfer && bus.txStart) proto_viol++;
                if (p_start && !p_xfer && (!bus.txStart || bus.txData !== p_data)) proto_viol++;
                if (busy_mode == 1) begin
                    b = (bcnt > 0);
                    if (bcnt > 0) bcnt--;
                end else if (busy_mode == 2) begin
                    b = ($urandom_range(2, 0) == 0);
                end else begin
                    b = 0;
                end
                bus.txBusy = b;
                p_xfer = bus.txStart && !b;
                if (p_xfer) begin
                    rx.push_back(bus.txData);
                    if (busy_mode == 1) bcnt = 10;
                end
                p_start = bus.txStart;
                p_data  = bus.txData;
            end
            if (bus.done) done_cnt++;
        end
    end

    // Packet model: header, hi/lo of each available word up to NW, XOR of payload bytes.
    function automatic int build_exp();
        int n;
        logic [7:0] x;
        logic [15:0] w;
        n = (pkt_words.size() < NW) ? pkt_words.size() : NW;
        x = 8'h00;
        exp_q.delete();
        exp_q.push_back(HDR);
        for (int i = 0; i < n; i++) begin
            w = pkt_words[i];
            exp_q.push_back(w[15:8]);
            exp_q.push_back(w[7:0]);
            x = x ^ w[15:8] ^ w[7:0];
        end
        exp_q.push_back(x);
        return n;
    endfunction

    function automatic int first_diff();
        int n;
        n = (rx.size() > exp_q.size()) ? rx.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            if (i >= rx.size() || i >= exp_q.size() || rx[i] !== exp_q[i]) return i;
        return -1;
    endfunction

    function automatic string pkt_msg(int idx);
        logic [7:0] g, w;
        g = (idx < rx.size()) ? rx[idx] : 8'h00;
        w = (idx < exp_q.size()) ? exp_q[idx] : 8'h00;
        return $sformatf("byte %0d got %02h want %02h (got %0d bytes want %0d)",
                         idx, g, w, rx.size(), exp_q.size());
    endfunction

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic run_packet(input int budget, output bit ok);
        int d0;
        d0 = done_cnt;
        rx.delete();
        bus.readoutStart = 1'b1;
        step();
        bus.readoutStart = 1'b0;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            if (done_cnt != d0) begin
                ok = 1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        bus.readoutStart = 1'b1;
        rst_n = 1'b0;
        repeat (3) step();
        checks++;
        if ({bus.dataRead, bus.txStart, bus.done, bus.busy} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 0000", {bus.dataRead, bus.txStart, bus.done, bus.busy});
        end
        checks++;
        if (bus.wordCount !== 8'd0) begin
            errors++;
            $display("FAIL reset_wordcount got %0d want 0", bus.wordCount);
        end
        checks++;
        if (bus.txData !== 8'h00) begin
            errors++;
            $display("FAIL reset_txdata got %02h want 00", bus.txData);
        end
        bus.readoutStart = 1'b0;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_normal(input int mode, input string nm);
        int d0, r0, pv0, n, idx;
        bit ok;
        busy_mode = mode; lat_min = 1; lat_max = 1;
        fifo_q.delete(); pkt_words.delete();
        fifo_q.push_back(16'h1234); fifo_q.push_back(16'hABCD);
        pkt_words = fifo_q;
        n = build_exp();
        d0 = done_cnt; r0 = rd_count; pv0 = proto_viol;
        run_packet(600, ok);
        repeat (3) step();
        checks++;
        if (!ok) begin errors++; $display("FAIL %s_done_timeout got none want done pulse", nm); end
        idx = first_diff();
        checks++;
        if (idx >= 0) begin errors++; $display("FAIL %s_bytes %s", nm, pkt_msg(idx)); end
        checks++;
        if (rx.size() != 6 || rx[5] !== 8'h40) begin
            errors++; $display("FAIL %s_trailer got size %0d want 6 bytes ending 40", nm, rx.size());
        end
        checks++;
        if (bus.wordCount !== 8'(n)) begin errors++; $display("FAIL %s_wordcount got %0d want %0d", nm, bus.wordCount, n); end
        checks++;
        if (done_cnt - d0 != 1) begin errors++; $display("FAIL %s_done_pulses got %0d want 1", nm, done_cnt - d0); end
        checks++;
        if (rd_count - r0 != 2) begin errors++; $display("FAIL %s_reads got %0d want 2", nm, rd_count - r0); end
        checks++;
        if (proto_viol != pv0) begin errors++; $display("FAIL %s_handshake got %0d violations want 0", nm, proto_viol - pv0); end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL %s_idle_busy got %b want 0", nm, bus.busy); end
    endtask

    task automatic test_underflow();
        int n, idx, d0;
        bit ok;
        busy_mode = 0; lat_min = 1; lat_max = 1;
        for (int pass = 0; pass < 2; pass++) begin
            fifo_q.delete(); pkt_words.delete();
            if (pass == 0) fifo_q.push_back(16'h00FF);
            pkt_words = fifo_q;
            n = build_exp();
            d0 = done_cnt;
            run_packet(200, ok);
            repeat (2) step();
            idx = first_diff();
            checks++;
            if (!ok || idx >= 0) begin errors++; $display("FAIL underflow%0d_bytes done=%0d %s", pass, ok, pkt_msg(idx)); end
            checks++;
            if (bus.wordCount !== 8'(n)) begin errors++; $display("FAIL underflow%0d_wordcount got %0d want %0d", pass, bus.wordCount, n); end
            checks++;
            if (done_cnt - d0 != 1) begin errors++; $display("FAIL underflow%0d_done got %0d want 1", pass, done_cnt - d0); end
        end
    endtask

    task automatic test_reset_mid();
        int n, idx;
        bit ok;
        busy_mode = 0; lat_min = 1; lat_max = 1;
        fifo_q.delete();
        fifo_q.push_back(16'h1234); fifo_q.push_back(16'hABCD);
        rx.delete();
        bus.readoutStart = 1'b1;
        step();
        bus.readoutStart = 1'b0;
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            if (rx.size() >= 3) begin ok = 1; break; end
            step();
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL resetmid_progress got %0d bytes want 3", rx.size()); end
        step();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({bus.dataRead, bus.txStart, bus.done, bus.busy, bus.wordCount, bus.txData} !== 20'h0) begin
            errors++;
            $display("FAIL resetmid_outputs got %h want 0",
                     {bus.dataRead, bus.txStart, bus.done, bus.busy, bus.wordCount, bus.txData});
        end
        step();
        rst_n = 1'b1;
        step();
        fifo_q.delete(); pkt_words.delete();
        fifo_q.push_back(16'h5A0F); fifo_q.push_back(16'h0101);
        pkt_words = fifo_q;
        n = build_exp();
        run_packet(200, ok);
        step();
        idx = first_diff();
        checks++;
        if (!ok || idx >= 0) begin errors++; $display("FAIL resetmid_fresh_packet done=%0d %s", ok, pkt_msg(idx)); end
        checks++;
        if (bus.wordCount !== 8'(n)) begin errors++; $display("FAIL resetmid_wordcount got %0d want %0d", bus.wordCount, n); end
    endtask

    task automatic test_latency_filter();
        int n, idx, d0, r0;
        bit ok;
        busy_mode = 0; lat_min = 3; lat_max = 3;
        fifo_q.delete(); pkt_words.delete();
        fifo_q.push_back(16'hC3E1); fifo_q.push_back(16'h7F80);
        pkt_words = fifo_q;
        fifo_q.push_back(16'h1111);
        n = build_exp();
        d0 = done_cnt; r0 = rd_count;
        rx.delete();
        bus.readoutStart = 1'b1;
        step();
        bus.readoutStart = 1'b0;
        repeat (4) step();
        checks++;
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL latency_busy got %b want 1", bus.busy); end
        bus.readoutStart = 1'b1;
        step();
        bus.readoutStart = 1'b0;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            if (done_cnt != d0) begin ok = 1; break; end
            step();
        end
        repeat (30) step();
        idx = first_diff();
        checks++;
        if (!ok || idx >= 0) begin errors++; $display("FAIL latency_bytes done=%0d %s", ok, pkt_msg(idx)); end
        checks++;
        if (done_cnt - d0 != 1) begin errors++; $display("FAIL filter_done got %0d want 1", done_cnt - d0); end
        checks++;
        if (rd_count - r0 != 2) begin errors++; $display("FAIL filter_reads got %0d want 2", rd_count - r0); end
        checks++;
        if (fifo_q.size() != 1 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL filter_leftover got %0d words busy %b want 1 word busy 0", fifo_q.size(), bus.busy);
        end
        checks++;
        if (bus.wordCount !== 8'(n)) begin errors++; $display("FAIL latency_wordcount got %0d want %0d", bus.wordCount, n); end
        lat_min = 1; lat_max = 1;
    endtask

    task automatic test_random();
        int k, n, idx, pv0;
        bit ok;
        logic [15:0] w;
        pv0 = proto_viol;
        for (int it = 0; it < 20; it++) begin
            k = $urandom_range(3, 0);
            busy_mode = 2; lat_min = 1; lat_max = $urandom_range(4, 1);
            fifo_q.delete(); pkt_words.delete();
            for (int j = 0; j < k; j++) begin
                w = 16'($urandom);
                fifo_q.push_back(w);
                pkt_words.push_back(w);
            end
            n = build_exp();
            run_packet(400, ok);
            step();
            idx = first_diff();
            checks++;
            if (!ok || idx >= 0) begin errors++; $display("FAIL random%0d_bytes done=%0d %s", it, ok, pkt_msg(idx)); end
            checks++;
            if (bus.wordCount !== 8'(n)) begin errors++; $display("FAIL random%0d_wordcount got %0d want %0d", it, bus.wordCount, n); end
        end
        checks++;
        if (proto_viol != pv0) begin errors++; $display("FAIL random_handshake got %0d violations want 0", proto_viol - pv0); end
        busy_mode = 0;
    endtask

    initial begin
        bus.readoutStart = 1'b0;
        test_reset();
        test_normal(0, "normal");
        test_normal(1, "backpressure");
        test_underflow();
        test_reset_mid();
        test_latency_filter();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
